// File: rtl/tetris_pkg.sv
// Shared types and helpers for the playfield line-clear stage.
// Holds the FSM state enum, width derivations and the score table.
package tetris_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    FILL,
    DONE
  } state_e;

  function automatic int row_w(input int h);
    return (h <= 2) ? 1 : $clog2(h);
  endfunction

  function automatic int cnt_w(input int h);
    return $clog2(h + 1);
  endfunction

  localparam logic [4:0][15:0] SCORE_TBL = {
    16'd8, 16'd5, 16'd3, 16'd1, 16'd0
  };

  function automatic logic [15:0] score_of(input logic [7:0] n);
    logic [2:0] i;
    i = (n >= 8'd4) ? 3'd4 : n[2:0];
    return SCORE_TBL[i];
  endfunction

endpackage

// File: rtl/row_full_detect.sv
// Combinational full-row detector: a row is full when every cell is nonzero.
module row_full_detect #(
  parameter int MEM_WIDTH = 4,
  parameter int WIDTH     = 8
) (
  input  logic [WIDTH*MEM_WIDTH-1:0] row,
  output logic                       full
);

  always_comb begin
    full = 1'b1;
    for (int i = 0; i < MEM_WIDTH; i++) begin
      if (row[i*WIDTH +: WIDTH] == '0) full = 1'b0;
    end
  end

endmodule

// File: rtl/row_clear.sv
// Line-clear stage: scans bottom-up, drops full rows, compacts, zero-fills.
// Optional score output enabled by defining ROW_CLEAR_SCORE_EN.
module row_clear
  import tetris_pkg::*;
#(
  parameter int MEM_WIDTH  = 4,
  parameter int MEM_HEIGHT = 4,
  parameter int WIDTH      = 8,
  parameter int ROW_W      = row_w(MEM_HEIGHT),
  parameter int CNT_W      = cnt_w(MEM_HEIGHT)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [ROW_W-1:0]           rd_addr,
  input  logic [WIDTH*MEM_WIDTH-1:0] rd_data,
  output logic                       wr_en,
  output logic [ROW_W-1:0]           wr_addr,
  output logic [WIDTH*MEM_WIDTH-1:0] wr_data,
  output logic [CNT_W-1:0]           lines_cleared,
  output logic [15:0]                total_lines
`ifdef ROW_CLEAR_SCORE_EN
  ,
  output logic [15:0]                score
`endif
);

  localparam int TOPI = MEM_HEIGHT - 1;
  localparam logic signed [ROW_W:0] TOP = TOPI[ROW_W:0];
  localparam logic signed [ROW_W:0] ONE = 1;

  state_e                  state_q, state_d;
  logic signed [ROW_W:0]   src_q, src_d;
  logic signed [ROW_W:0]   dst_q, dst_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        lines_q, lines_d;
  logic [15:0]             total_q, total_d;
  logic [16:0]             total_sum;
  logic                    full;

  row_full_detect #(
    .MEM_WIDTH (MEM_WIDTH),
    .WIDTH     (WIDTH)
  ) u_full (
    .row  (rd_data),
    .full (full)
  );

  assign total_sum = {1'b0, total_q} + 17'(cnt_q);

`ifdef ROW_CLEAR_SCORE_EN
  logic [15:0] score_q, score_d;
  logic [16:0] score_sum;

  assign score_sum = {1'b0, score_q}
                   + {1'b0, score_of(8'(cnt_q))};
  assign score     = score_q;

  always_comb begin
    score_d = score_q;
    if (state_q == DONE) begin
      score_d = score_sum[16] ? 16'hFFFF
                              : score_sum[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) score_q <= '0;
    else      score_q <= score_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    lines_d = lines_q;
    total_d = total_q;
    busy    = 1'b0;
    done    = 1'b0;
    rd_addr = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          src_d   = TOP;
          dst_d   = TOP;
          cnt_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        busy    = 1'b1;
        rd_addr = src_q[ROW_W-1:0];
        if (full) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          wr_en   = (src_q != dst_q);
          wr_addr = dst_q[ROW_W-1:0];
          wr_data = rd_data;
          dst_d   = dst_q - ONE;
        end
        src_d = src_q - ONE;
        if (src_q == '0) begin
          state_d = (cnt_d != '0) ? FILL : DONE;
        end
      end
      FILL: begin
        busy    = 1'b1;
        wr_en   = 1'b1;
        wr_addr = dst_q[ROW_W-1:0];
        dst_d   = dst_q - ONE;
        if (dst_q == '0) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        lines_d = cnt_q;
        total_d = total_sum[16] ? 16'hFFFF
                                : total_sum[15:0];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      lines_q <= '0;
      total_q <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      lines_q <= lines_d;
      total_q <= total_d;
    end
  end

  assign lines_cleared = lines_q;
  assign total_lines   = total_q;

endmodule

// File: tb/tb_row_clear.sv
// Self-checking bench for row_clear: table vectors, random fields
// against a compaction model, and start/reset/saturation sequences.
module tb_row_clear;

  typedef logic [3:0][31:0] fld_t;

  typedef struct {
    string          nm;
    fld_t           f;
    int             nw;
    logic [7:0][1:0]  wa;
    logic [7:0][31:0] wd;
    int             lines;
  } vec_t;

  localparam logic [31:0] RA = 32'h0011_0022;
  localparam logic [31:0] RB = 32'h3300_0000;
  localparam logic [31:0] RC = 32'h0000_0044;
  localparam logic [31:0] RF = 32'h0101_0101;
  localparam logic [31:0] RG = 32'hFF7F_8001;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, wr_en;
  logic [1:0]  rd_addr, wr_addr;
  logic [31:0] rd_data, wr_data;
  logic [2:0]  lines_cleared;
  logic [15:0] total_lines;
`ifdef ROW_CLEAR_SCORE_EN
  logic [15:0] score;
`endif

  logic [31:0] mem [4];
  logic        ld_en = 1'b0;
  fld_t        ld_val = '0;
  logic [33:0] wq [$];
  int          bad_wr = 0;

  int tests = 0;
  int fails = 0;
  int tot_m = 0;
  int sc_m  = 0;

  always #5 clk = ~clk;

  row_clear dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .lines_cleared (lines_cleared),
    .total_lines   (total_lines)
`ifdef ROW_CLEAR_SCORE_EN
    ,
    .score         (score)
`endif
  );

  assign rd_data = mem[rd_addr];

  always @(posedge clk) begin
    if (ld_en) begin
      for (int i = 0; i < 4; i++) mem[i] <= ld_val[i];
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
      wq.push_back({wr_addr, wr_data});
    end
    if (wr_en && !busy) bad_wr++;
  end

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic bit is_full(input logic [31:0] r);
    return r[7:0] != 0 && r[15:8] != 0 &&
           r[23:16] != 0 && r[31:24] != 0;
  endfunction

  function automatic int sc_tbl(input int n);
    int t [5] = '{0, 1, 3, 5, 8};
    return t[(n > 4) ? 4 : n];
  endfunction

  // Surviving rows keep their bottom-up order and sink to the bottom.
  task automatic model(input fld_t f, output fld_t e,
                       output int n, output int nw);
    logic [31:0] kept [$];
    e = '0;
    n = 0;
    nw = 0;
    for (int r = 3; r >= 0; r--) begin
      if (is_full(f[r])) n++;
      else kept.push_back(f[r]);
    end
    for (int i = 0; i < kept.size(); i++) e[3-i] = kept[i];
    for (int r = 3, k = 3; r >= 0; r--) begin
      if (!is_full(f[r])) begin
        if (k != r) nw++;
        k--;
      end
    end
    nw += n;
  endtask

  task automatic load(input fld_t f);
    @(negedge clk);
    ld_val = f;
    ld_en  = 1'b1;
    @(negedge clk);
    ld_en  = 1'b0;
  endtask

  task automatic do_pass(output int lat, output logic [1:0] ra1,
                         output logic b1);
    lat = -1;
    ra1 = 'x;
    b1  = 1'bx;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i < 40; i++) begin
      if (i > 1) @(negedge clk);
      if (i == 1) begin
        ra1 = rd_addr;
        b1  = busy;
      end
      if (done) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) $display("FAIL done_timeout: no done within 40 cycles");
    @(negedge clk);
  endtask

  task automatic run_and_check(input string nm);
    fld_t cur, e, fin;
    int n, nw, lat;
    logic [1:0] ra1;
    logic b1;
    for (int i = 0; i < 4; i++) cur[i] = mem[i];
    model(cur, e, n, nw);
    wq.delete();
    do_pass(lat, ra1, b1);
    tot_m = (tot_m + n > 65535) ? 65535 : tot_m + n;
    sc_m  = (sc_m + sc_tbl(n) > 65535) ? 65535 : sc_m + sc_tbl(n);
    for (int i = 0; i < 4; i++) fin[i] = mem[i];
    chk({nm, "/latency"}, 128'(lat), 128'(4 + n + 1));
    chk({nm, "/rd_first"}, 128'(ra1), 128'(3));
    chk({nm, "/busy"}, 128'(b1), 128'(1));
    chk({nm, "/lines"}, 128'(lines_cleared), 128'(n));
    chk({nm, "/total"}, 128'(total_lines), 128'(tot_m));
    chk({nm, "/field"}, 128'(fin), 128'(e));
    chk({nm, "/nwrites"}, 128'(wq.size()), 128'(nw));
`ifdef ROW_CLEAR_SCORE_EN
    chk({nm, "/score"}, 128'(score), 128'(sc_m));
`endif
  endtask

  vec_t vt [5];

  initial begin
    fld_t f;
    int ndone, first;

    vt[0] = '{nm:"empty", f:'0, nw:0, wa:'0, wd:'0, lines:0};
    vt[1].nm = "row3_full";
    vt[1].f  = {RF, RA, RB, RC};
    vt[1].nw = 4;
    vt[1].wa = {8'b0, 2'd0, 2'd1, 2'd2, 2'd3};
    vt[1].wd = {128'b0, 32'h0, RC, RB, RA};
    vt[1].lines = 1;
    vt[2].nm = "rows13_full";
    vt[2].f  = {RG, RA, RF, RC};
    vt[2].nw = 4;
    vt[2].wa = {8'b0, 2'd0, 2'd1, 2'd2, 2'd3};
    vt[2].wd = {128'b0, 32'h0, 32'h0, RC, RA};
    vt[2].lines = 2;
    vt[3].nm = "all_full";
    vt[3].f  = {RF, RG, RF, RG};
    vt[3].nw = 4;
    vt[3].wa = {8'b0, 2'd0, 2'd1, 2'd2, 2'd3};
    vt[3].wd = '0;
    vt[3].lines = 4;
    vt[4].nm = "row0_full";
    vt[4].f  = {RC, RB, RA, RF};
    vt[4].nw = 1;
    vt[4].wa = '0;
    vt[4].wd = '0;
    vt[4].lines = 1;

    repeat (3) @(negedge clk);
    chk("rst/busy", 128'(busy), 0);
    chk("rst/done", 128'(done), 0);
    chk("rst/wr_en", 128'(wr_en), 0);
    chk("rst/rd_addr", 128'(rd_addr), 0);
    chk("rst/wr_addr", 128'(wr_addr), 0);
    chk("rst/wr_data", 128'(wr_data), 0);
    chk("rst/lines", 128'(lines_cleared), 0);
    chk("rst/total", 128'(total_lines), 0);
`ifdef ROW_CLEAR_SCORE_EN
    chk("rst/score", 128'(score), 0);
`endif
    rst = 1'b1;

    for (int v = 0; v < 5; v++) begin
      load(vt[v].f);
      run_and_check(vt[v].nm);
      chk({vt[v].nm, "/tbl_lines"}, 128'(lines_cleared),
          128'(vt[v].lines));
      for (int i = 0; i < vt[v].nw && i < wq.size(); i++)
        chk($sformatf("%s/wr%0d", vt[v].nm, i), 128'(wq[i]),
            128'({vt[v].wa[i], vt[v].wd[i]}));
    end

    for (int t = 0; t < 40; t++) begin
      for (int r = 0; r < 4; r++) begin
        if ($urandom_range(0, 1) == 1) begin
          for (int c = 0; c < 4; c++)
            f[r][c*8 +: 8] = 8'($urandom_range(1, 255));
        end else begin
          f[r] = $urandom;
          f[r][$urandom_range(0, 3)*8 +: 8] = 8'h00;
        end
      end
      load(f);
      run_and_check($sformatf("rand%0d", t));
    end

    // Second start while scanning must not queue another pass.
    load({RF, RA, RB, RC});
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    first = -1;
    for (int i = 1; i < 20; i++) begin
      if (i > 1) @(negedge clk);
      if (i == 2) start = 1'b1;
      if (i == 3) start = 1'b0;
      if (done) begin
        ndone++;
        if (first < 0) first = i;
      end
    end
    tot_m += 1;
    sc_m  += 1;
    chk("dbl_start/ndone", 128'(ndone), 1);
    chk("dbl_start/lat", 128'(first), 6);
    chk("dbl_start/total", 128'(total_lines), 128'(tot_m));

    // Reset in the middle of FILL.
    load({RF, RF, RF, RF});
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("midfill/pre_busy", 128'(busy), 1);
    chk("midfill/pre_wr", 128'(wr_en), 1);
    rst = 1'b0;
    #1;
    chk("midfill/wr_en", 128'(wr_en), 0);
    chk("midfill/busy", 128'(busy), 0);
    chk("midfill/total", 128'(total_lines), 0);
    chk("midfill/wr_addr", 128'(wr_addr), 0);
    @(negedge clk);
    rst = 1'b1;
    tot_m = 0;
    sc_m  = 0;
    run_and_check("restart");

    // Saturation of the running total.
    force dut.total_q = 16'hFFF0;
    @(posedge clk);
    @(negedge clk);
    release dut.total_q;
    @(negedge clk);
    tot_m = 16'hFFF0;
    chk("sat/preload", 128'(total_lines), 128'(16'hFFF0));
    for (int k = 0; k < 6; k++) begin
      load({RF, RG, RF, RG});
      run_and_check($sformatf("sat%0d", k));
    end
    chk("sat/final", 128'(total_lines), 128'(16'hFFFF));

    chk("wr_outside_busy", 128'(bad_wr), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
